// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared types for the branch resolve unit:
//     br_op_e      - encoding of the 3-bit 'br' request field
//     bru_state_e  - control FSM state type
//     BHT_INIT     - power-on value of every branch history counter
//     bht_next()   - 2-bit saturating counter step
// ---------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JAL  = 3'd7
  } br_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_FLUSH   = 2'd2
  } bru_state_e;

  // Flush counter width; covers FLUSH_CYCLES up to 15.
  localparam int FLUSH_CNT_W = 4;

  // Weakly-not-taken.
  localparam logic [1:0] BHT_INIT = 2'b01;

  // Saturating up/down step of a 2-bit prediction counter.
  function automatic logic [1:0] bht_next(input logic [1:0] ctr,
                                          input logic       taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != 2'b11))       nxt = ctr + 2'b01;
    else if (!taken && (ctr != 2'b00)) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// ---------------------------------------------------------------------------
// branch_history_table
//   DEPTH-entry table of 2-bit saturating direction counters. Present only
//   in builds that define BRU_BHT_EN (instantiated by branch_resolve_unit).
//
// Ports
//   clk, reset    clock, synchronous active-high reset (all entries -> 01)
//   upd_en        update strobe (one resolved branch this cycle)
//   upd_idx       entry to update
//   upd_taken     resolved direction: increment if 1, decrement if 0
//   lookup_idx    entry to read
//   lookup_taken  combinational prediction (counter MSB)
// ---------------------------------------------------------------------------
module branch_history_table
  import riscv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_taken
);

  logic [1:0] ctr [DEPTH];

  // NOTE: this table is register-based and small, so every entry is reset;
  // a RAM-backed table could not be cleared in one cycle like this.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= BHT_INIT;
    end else if (upd_en) begin
      ctr[upd_idx] <= bht_next(ctr[upd_idx], upd_taken);
    end
  end

  assign lookup_taken = ctr[lookup_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves a conditional branch / JAL one cycle after acceptance, reports
//   the target, detects a mispredict against the fetch-stage guess and then
//   holds a flush window before accepting new work.
//
//   Optional feature: define BRU_BHT_EN to add a branch history table
//   (branch_history_table) with a combinational lookup port. Default build
//   has no table and no lookup ports.
//
// Parameters
//   XLEN          operand / address width
//   FLUSH_CYCLES  cycles flush is held after a mispredict (1..15)
//   BHT_DEPTH     BHT entries, power of two (BRU_BHT_EN only)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid, in_ready  request handshake
//   br                  op (0 none, 1 BEQ .. 6 BGEU, 7 JAL)
//   pc, rs1, rs2, imm   branch PC, operands, byte offset
//   pred_taken          fetch-stage prediction
//   lookup_pc           BHT lookup address          (BRU_BHT_EN only)
//   lookup_taken        BHT prediction for lookup_pc (BRU_BHT_EN only)
//   out_valid           result valid (one cycle after acceptance)
//   taken, target       resolved direction, pc+imm
//   redirect            mispredict pulse
//   redirect_pc         corrected fetch PC
//   flush               squash younger stages
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int BHT_DEPTH    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      br,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
`ifdef BRU_BHT_EN
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
`endif
  output logic            out_valid,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush
);

  bru_state_e             state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;  // FLUSH cycles left, including current

  br_op_e          op;
  logic            accept;
  logic            cond_taken;
  logic            mispredict;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] fall_c;

  assign op = br_op_e'(br);

  // A mispredicting RESOLVE cycle already stalls the front end.
  assign in_ready = !reset &&
                    ((state == ST_IDLE) || ((state == ST_RESOLVE) && !redirect));

  assign accept = in_valid && in_ready && (op != BR_NONE);

  // NOTE: the default assignment first keeps this block purely
  // combinational; leaving cond_taken unassigned on any path infers a latch.
  always_comb begin
    cond_taken = 1'b0;
    case (op)
      BR_BEQ:  cond_taken = (rs1 == rs2);
      BR_BNE:  cond_taken = (rs1 != rs2);
      BR_BLT:  cond_taken = ($signed(rs1) <  $signed(rs2));
      BR_BGE:  cond_taken = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: cond_taken = (rs1 <  rs2);
      BR_BGEU: cond_taken = (rs1 >= rs2);
      BR_JAL:  cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  // Both sums wrap modulo 2^XLEN by construction.
  assign target_c   = pc + imm;
  assign fall_c     = pc + XLEN'(4);
  assign mispredict = (cond_taken != pred_taken);

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // later reads in the same block therefore see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      flush_cnt   <= '0;
      out_valid   <= 1'b0;
      taken       <= 1'b0;
      target      <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
    end else begin
      // Result registers carry a value only in the cycle after an accept;
      // otherwise they return to zero.
      out_valid   <= accept;
      taken       <= accept && cond_taken;
      target      <= accept ? target_c : '0;
      redirect    <= accept && mispredict;
      redirect_pc <= accept ? (cond_taken ? target_c : fall_c) : '0;

      unique case (state)
        ST_FLUSH: begin
          // The flush window started in the RESOLVE cycle, so it ends one
          // cycle before the FLUSH state does.
          if (flush_cnt <= 4'd1) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            flush     <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
            flush     <= (flush_cnt > 4'd2);
          end
        end

        ST_RESOLVE: begin
          if (redirect) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES);
            flush     <= (FLUSH_CYCLES > 1);
          end else if (accept) begin
            state <= ST_RESOLVE;
            flush <= mispredict;
          end else begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end
        end

        default: begin  // ST_IDLE
          if (accept) begin
            state <= ST_RESOLVE;
            flush <= mispredict;
          end else begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef BRU_BHT_EN
  localparam int IDX_W = $clog2(BHT_DEPTH);

  // Index of the branch currently in RESOLVE; the counter is trained at the
  // end of that cycle with the registered direction.
  logic [IDX_W-1:0] res_idx;
  logic             unused_lookup_bits;

  always_ff @(posedge clk) begin
    if (reset)       res_idx <= '0;
    else if (accept) res_idx <= pc[IDX_W+1:2];
  end

  // Only the word-index bits of lookup_pc select an entry.
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

  branch_history_table #(
    .DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk          (clk),
    .reset        (reset),
    .upd_en       (out_valid),
    .upd_idx      (res_idx),
    .upd_taken    (taken),
    .lookup_idx   (lookup_pc[IDX_W+1:2]),
    .lookup_taken (lookup_taken)
  );
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Self-checking bench for branch_resolve_unit (XLEN=32, FLUSH_CYCLES=2).
//   A cycle-level reference model tracks the expected result, the remaining
//   stall / flush cycles and (with BRU_BHT_EN) the prediction counters.
//   Directed cases come first, then a randomized run with occasional resets.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      br;
  logic [XLEN-1:0] pc, rs1, rs2, imm;
  logic            pred_taken;
  logic            out_valid, taken, redirect, flush;
  logic [XLEN-1:0] target, redirect_pc;
  logic [XLEN-1:0] lookup_pc;
`ifdef BRU_BHT_EN
  logic            lookup_taken;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (FC),
    .BHT_DEPTH    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .br           (br),
    .pc           (pc),
    .rs1          (rs1),
    .rs2          (rs2),
    .imm          (imm),
    .pred_taken   (pred_taken),
`ifdef BRU_BHT_EN
    .lookup_pc    (lookup_pc),
    .lookup_taken (lookup_taken),
`endif
    .out_valid    (out_valid),
    .taken        (taken),
    .target       (target),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .flush        (flush)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_block = 0;   // cycles left with the unit refusing requests
  int          m_flush = 0;   // cycles left with flush high
  logic        e_valid = 0, e_taken = 0, e_redirect = 0;
  logic [31:0] e_target = 0, e_rpc = 0, e_pc = 0;
  int          bht [16];
  logic        last_ready;
  logic        last_lookup;

  function automatic logic ref_taken(input int op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      1: return a == b;
      2: return a != b;
      3: return sa < sb;
      4: return sa >= sb;
      5: return a < b;
      6: return a >= b;
      7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int bht_idx(input logic [31:0] a);
    return int'((a >> 2) % 32'd16);
  endfunction

  // One clock cycle: drive at negedge, check in_ready/lookup, model the
  // edge, check the registered outputs 1 ns after it.
  task automatic cycle(input logic rst, input logic v, input logic [2:0] op,
                       input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] i,
                       input logic pt, input logic [31:0] lpc);
    logic acc, t, exp_ready;
    @(negedge clk);
    reset = rst; in_valid = v; br = op; pc = p; rs1 = a; rs2 = b; imm = i;
    pred_taken = pt; lookup_pc = lpc;
    #1;
    exp_ready  = rst ? 1'b0 : (m_block == 0);
    last_ready = in_ready;
    check("in_ready", in_ready, exp_ready);
`ifdef BRU_BHT_EN
    last_lookup = lookup_taken;
    check("lookup_taken", lookup_taken, bht[bht_idx(lpc)] >= 2);
`endif
    acc = !rst && v && exp_ready && (op != 3'd0);
    @(posedge clk);
    if (rst) begin
      m_block = 0; m_flush = 0;
      e_valid = 0; e_taken = 0; e_redirect = 0; e_target = 0; e_rpc = 0;
      foreach (bht[k]) bht[k] = 1;
    end else begin
      if (e_valid) begin
        if (e_taken) bht[bht_idx(e_pc)] = (bht[bht_idx(e_pc)] == 3) ? 3 : bht[bht_idx(e_pc)] + 1;
        else         bht[bht_idx(e_pc)] = (bht[bht_idx(e_pc)] == 0) ? 0 : bht[bht_idx(e_pc)] - 1;
      end
      if (m_block > 0) m_block--;
      if (m_flush > 0) m_flush--;
      if (acc) begin
        t          = ref_taken(int'(op), a, b);
        e_valid    = 1;
        e_taken    = t;
        e_target   = p + i;
        e_rpc      = t ? p + i : p + 32'd4;
        e_redirect = (t != pt);
        e_pc       = p;
        if (e_redirect) begin
          m_block = FC + 1;
          m_flush = FC;
        end
      end else begin
        e_valid = 0; e_taken = 0; e_redirect = 0; e_target = 0; e_rpc = 0;
      end
    end
    #1;
    check("out_valid",   out_valid,   e_valid);
    check("taken",       taken,       e_taken);
    check("target",      target,      e_target);
    check("redirect",    redirect,    e_redirect);
    check("redirect_pc", redirect_pc, e_rpc);
    check("flush",       flush,       m_flush > 0);
  endtask

  task automatic idle(input int n, input logic [31:0] lpc);
    for (int k = 0; k < n; k++) cycle(0, 0, 3'd0, 0, 0, 0, 0, 0, lpc);
  endtask

  logic [31:0] vals [6] = '{32'h0, 32'h1, 32'h5, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'h7FFF_FFFF};

  initial begin
    int n_low, n_fl;
    foreach (bht[k]) bht[k] = 1;
    reset = 1; in_valid = 0; br = 0; pc = 0; rs1 = 0; rs2 = 0; imm = 0;
    pred_taken = 0; lookup_pc = 0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_flush", flush, 0);
    idle(1, 0);
    check("ready_after_release", last_ready, 1);

    // BEQ equal, correctly predicted taken
    cycle(0, 1, 3'd1, 32'h100, 5, 5, 32'h20, 1, 0);
    check("beq_valid", out_valid, 1);
    check("beq_taken", taken, 1);
    check("beq_target", target, 32'h120);
    check("beq_redirect", redirect, 0);
    check("beq_flush", flush, 0);
    idle(1, 0);
    check("idle_target_zero", target, 0);

    // BLT signed -1 < 1, predicted not taken: mispredict
    cycle(0, 1, 3'd3, 32'h300, 32'hFFFF_FFFF, 1, 32'h40, 0, 0);
    check("blt_taken", taken, 1);
    check("blt_redirect", redirect, 1);
    check("blt_rpc", redirect_pc, 32'h340);
    n_fl = flush ? 1 : 0;
    n_low = 0;
    // Requests offered during the stall must be ignored.
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 3'd1, 32'h500, 1, 1, 32'h8, 1, 0);
      if (!last_ready) n_low++;
      if (k < 3 && flush) n_fl++;
    end
    check("blt_ready_low_cycles", n_low, 3);
    check("blt_flush_cycles", n_fl, 2);
    idle(1, 0);

    // BLTU unsigned 0xFFFFFFFF < 1 false, predicted taken
    cycle(0, 1, 3'd5, 32'h200, 32'hFFFF_FFFF, 1, 32'h80, 1, 0);
    check("bltu_taken", taken, 0);
    check("bltu_redirect", redirect, 1);
    check("bltu_rpc", redirect_pc, 32'h204);
    idle(4, 0);

    // JAL wrap-around
    cycle(0, 1, 3'd7, 32'hFFFF_FFF0, 0, 0, 32'h20, 1, 0);
    check("jal_target_wrap", target, 32'h10);
    check("jal_redirect", redirect, 0);
    idle(1, 0);

    // Reset on the first FLUSH cycle
    cycle(0, 1, 3'd1, 32'h600, 7, 7, 32'h10, 0, 0);
    idle(1, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_flush_clear", flush, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_ready_held_low", last_ready, 0);
    idle(1, 0);
    check("rst_release_ready", last_ready, 1);
    check("rst_no_residual_flush", flush, 0);

`ifdef BRU_BHT_EN
    // Three taken resolves at 0x40 saturate the counter at 11.
    for (int k = 0; k < 3; k++) cycle(0, 1, 3'd7, 32'h40, 0, 0, 32'h4, 1, 32'h40);
    idle(2, 32'h40);
    check("bht_taken_after_3", last_lookup, 1);
    // One not-taken from 11 -> 10, still predicts taken.
    cycle(0, 1, 3'd2, 32'h40, 3, 3, 32'h4, 0, 32'h40);
    idle(2, 32'h40);
    check("bht_saturated", last_lookup, 1);
    cycle(0, 1, 3'd2, 32'h40, 3, 3, 32'h4, 0, 32'h40);
    idle(2, 32'h40);
    check("bht_weak_not_taken", last_lookup, 0);
`endif

    // Randomized run
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, b, p;
      a = ($urandom_range(0, 1) == 0) ? vals[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : vals[$urandom_range(0, 5)];
      p = {24'h0, 4'($urandom_range(0, 15)), 4'h0} + 32'($urandom_range(0, 3) * 4);
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 8),
            3'($urandom_range(0, 7)), p, a, b, $urandom, 1'($urandom_range(0, 1)),
            {24'h0, 4'($urandom_range(0, 15)), 4'h0});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
